// File: rtl/ball_motion.sv
// Ball position/direction engine for a breakout-style game on a 16x16 grid.
// Handles serve, wall/brick/paddle reflection, life loss and game over.
module ball_motion #(
  parameter int PADDLE_W    = 4,
  parameter int START_LIVES = 3,
  parameter int LOST_WAIT   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        move_tick,
  input  logic        launch,
  input  logic [3:0]  paddle_col,
  input  logic [55:0] Bricks,
  output logic [3:0]  Ball_rowIndex,
  output logic [3:0]  Ball_colIndex,
  output logic [1:0]  Ball_direction,
  output logic [1:0]  lives,
  output logic        ball_lost,
  output logic        game_over
);

  typedef enum logic [1:0] {IDLE, FLY, LOST, OVER} state_t;

  localparam logic [4:0] PW_M1    = 5'(PADDLE_W - 1);
  localparam logic [1:0] LAST_CNT = 2'(LOST_WAIT - 1);

  state_t     state;
  logic [1:0] lost_cnt;

  logic [3:0] idle_col;
  logic [3:0] step_row;
  logic [3:0] step_col;
  logic [1:0] step_dir;
  logic       step_lost;
  logic [3:0] target_row;
  logic [5:0] brick_idx;
  logic       brick_hit;
  logic [4:0] paddle_right;
  logic       on_paddle;

  assign idle_col = (paddle_col == 4'd15) ? 4'd15 : paddle_col + 4'd1;

  // One flight step: horizontal move first, then top wall, brick, paddle in priority order.
  always_comb begin
    step_row  = Ball_rowIndex;
    step_col  = Ball_colIndex;
    step_dir  = Ball_direction;
    step_lost = 1'b0;

    if (!Ball_direction[0] && Ball_colIndex == 4'd0) begin
      step_dir[0] = 1'b1;
      step_col    = 4'd1;
    end else if (Ball_direction[0] && Ball_colIndex == 4'd15) begin
      step_dir[0] = 1'b0;
      step_col    = 4'd14;
    end else if (Ball_direction[0]) begin
      step_col = Ball_colIndex + 4'd1;
    end else begin
      step_col = Ball_colIndex - 4'd1;
    end

    // Wraps only when the top wall branch below takes over.
    target_row   = Ball_direction[1] ? Ball_rowIndex + 4'd1 : Ball_rowIndex - 4'd1;
    brick_idx    = {target_row[2:0] - 3'd1, step_col[3:1]};
    brick_hit    = !target_row[3] && (target_row != 4'd0) && Bricks[brick_idx];
    paddle_right = {1'b0, paddle_col} + PW_M1;
    on_paddle    = (step_col >= paddle_col) && ({1'b0, step_col} <= paddle_right);

    if (!Ball_direction[1] && Ball_rowIndex == 4'd0) begin
      step_dir[1] = 1'b1;
      step_row    = 4'd1;
    end else if (brick_hit) begin
      step_dir[1] = ~Ball_direction[1];
    end else if (Ball_direction[1] && Ball_rowIndex == 4'd14) begin
      if (on_paddle) begin
        step_dir[1] = 1'b0;
      end else begin
        step_row  = 4'd15;
        step_lost = 1'b1;
      end
    end else begin
      step_row = target_row;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      Ball_rowIndex  <= 4'd14;
      Ball_colIndex  <= 4'd7;
      Ball_direction <= 2'b01;
      lives          <= 2'(START_LIVES);
      ball_lost      <= 1'b0;
      game_over      <= 1'b0;
      lost_cnt       <= 2'd0;
    end else begin
      ball_lost <= 1'b0;
      case (state)
        IDLE: begin
          Ball_rowIndex  <= 4'd14;
          Ball_colIndex  <= idle_col;
          Ball_direction <= 2'b01;
          if (launch) state <= FLY;
        end
        FLY: begin
          if (move_tick) begin
            Ball_rowIndex  <= step_row;
            Ball_colIndex  <= step_col;
            Ball_direction <= step_dir;
            if (step_lost) begin
              state     <= LOST;
              ball_lost <= 1'b1;
              lost_cnt  <= 2'd0;
              if (lives != 2'd0) lives <= lives - 2'd1;
            end
          end
        end
        LOST: begin
          // Ball sits below the paddle until enough move ticks have elapsed.
          if (move_tick) begin
            if (lost_cnt == LAST_CNT) begin
              lost_cnt <= 2'd0;
              if (lives != 2'd0) begin
                state <= IDLE;
              end else begin
                state     <= OVER;
                game_over <= 1'b1;
              end
            end else begin
              lost_cnt <= lost_cnt + 2'd1;
            end
          end
        end
        OVER: game_over <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion: expectations are queued as stimulus is driven
// and checked just after the clock edge that should produce them.
module tb_ball_motion;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        move_tick = 1'b0;
  logic        launch = 1'b0;
  logic [3:0]  paddle_col = 4'd5;
  logic [55:0] Bricks = '0;
  logic [3:0]  Ball_rowIndex;
  logic [3:0]  Ball_colIndex;
  logic [1:0]  Ball_direction;
  logic [1:0]  lives;
  logic        ball_lost;
  logic        game_over;

  ball_motion dut (
    .clock          (clock),
    .reset          (reset),
    .move_tick      (move_tick),
    .launch         (launch),
    .paddle_col     (paddle_col),
    .Bricks         (Bricks),
    .Ball_rowIndex  (Ball_rowIndex),
    .Ball_colIndex  (Ball_colIndex),
    .Ball_direction (Ball_direction),
    .lives          (lives),
    .ball_lost      (ball_lost),
    .game_over      (game_over)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      tag;
    logic [3:0] row;
    logic [3:0] col;
    logic [1:0] dir;
    logic [1:0] lv;
    logic       lost;
    logic       over;
  } exp_t;

  localparam logic [55:0] ALL_BRICKS = '1;
  localparam logic [55:0] BRICK_52   = 56'(1) << 52;

  exp_t       sbq[$];
  int         total = 0;
  int         bad = 0;
  logic [1:0] cur_lives = 2'd3;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, obs, expv);
    end
  endtask

  task automatic pushExp(input string tag, input logic [3:0] r, input logic [3:0] c,
                         input logic [1:0] d, input logic [1:0] lv, input logic lost,
                         input logic over);
    exp_t e;
    e.tag = tag; e.row = r; e.col = c; e.dir = d; e.lv = lv; e.lost = lost; e.over = over;
    sbq.push_back(e);
  endtask

  task automatic popAndCheck();
    exp_t e;
    checkOutput("sb_pending", 8'(sbq.size()), 8'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checkOutput($sformatf("%s.row", e.tag),  {4'd0, Ball_rowIndex},  {4'd0, e.row});
      checkOutput($sformatf("%s.col", e.tag),  {4'd0, Ball_colIndex},  {4'd0, e.col});
      checkOutput($sformatf("%s.dir", e.tag),  {6'd0, Ball_direction}, {6'd0, e.dir});
      checkOutput($sformatf("%s.lives", e.tag), {6'd0, lives},         {6'd0, e.lv});
      checkOutput($sformatf("%s.lost", e.tag), {7'd0, ball_lost},      {7'd0, e.lost});
      checkOutput($sformatf("%s.over", e.tag), {7'd0, game_over},      {7'd0, e.over});
    end
  endtask

  task automatic applyStimulus(input logic tick, input logic lch, input logic [3:0] pcol,
                               input logic [55:0] br);
    @(negedge clock);
    move_tick  = tick;
    launch     = lch;
    paddle_col = pcol;
    Bricks     = br;
  endtask

  task automatic stepChecked(input string tag, input logic tick, input logic lch,
                             input logic [3:0] pcol, input logic [55:0] br,
                             input logic [3:0] r, input logic [3:0] c, input logic [1:0] d,
                             input logic [1:0] lv, input logic lost, input logic over);
    applyStimulus(tick, lch, pcol, br);
    pushExp(tag, r, c, d, lv, lost, over);
    @(posedge clock);
    #1;
    popAndCheck();
  endtask

  // Reset is asserted between edges so its effect must appear without a clock.
  task automatic doReset(input string tag);
    @(negedge clock);
    reset = 1'b0;
    move_tick = 1'b0;
    launch = 1'b0;
    #2;
    cur_lives = 2'd3;
    pushExp(tag, 4'd14, 4'd7, 2'b01, 2'd3, 1'b0, 1'b0);
    popAndCheck();
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Serve from paddle 0, bounce off a row-7 brick, miss the paddle, sit out LOST.
  task automatic runLoss();
    logic [1:0] after;
    after = (cur_lives == 2'd0) ? 2'd0 : cur_lives - 2'd1;
    stepChecked("serve_with_tick", 1, 1, 4'd0, '0, 4'd14, 4'd1, 2'b01, cur_lives, 0, 0);
    for (int j = 1; j <= 6; j++)
      stepChecked($sformatf("loss_up%0d", j), 1, 0, 4'd0, '0, 4'(14 - j), 4'(1 + j), 2'b01,
                  cur_lives, 0, 0);
    stepChecked("loss_brick", 1, 0, 4'd0, ALL_BRICKS, 4'd8, 4'd8, 2'b11, cur_lives, 0, 0);
    for (int j = 8; j <= 13; j++)
      stepChecked($sformatf("loss_down%0d", j), 1, 0, 4'd0, '0, 4'(j + 1), 4'(j + 1), 2'b11,
                  cur_lives, 0, 0);
    stepChecked("loss_miss", 1, 0, 4'd0, '0, 4'd15, 4'd15, 2'b11, after, 1, 0);
    cur_lives = after;
    stepChecked("lost_pulse_clear", 0, 0, 4'd0, '0, 4'd15, 4'd15, 2'b11, cur_lives, 0, 0);
    for (int t = 1; t <= 3; t++)
      stepChecked($sformatf("lost_tick%0d", t), 1, 0, 4'd0, '0, 4'd15, 4'd15, 2'b11,
                  cur_lives, 0, 0);
    stepChecked("lost_hold", 0, 0, 4'd0, '0, 4'd15, 4'd15, 2'b11, cur_lives, 0, 0);
    stepChecked("lost_done", 1, 0, 4'd0, '0, 4'd15, 4'd15, 2'b11, cur_lives, 0,
                cur_lives == 2'd0);
    if (cur_lives != 2'd0)
      stepChecked("reserve_idle", 0, 0, 4'd0, '0, 4'd14, 4'd1, 2'b01, cur_lives, 0, 0);
    else
      stepChecked("over_frozen", 0, 0, 4'd0, '0, 4'd15, 4'd15, 2'b11, 2'd0, 0, 1);
  endtask

  initial begin
    // Serve from paddle 5 and IDLE tracking.
    doReset("reset_initial");
    stepChecked("idle_track", 0, 0, 4'd5, '0, 4'd14, 4'd6, 2'b01, 2'd3, 0, 0);
    stepChecked("idle_tick_ignored", 1, 0, 4'd5, '0, 4'd14, 4'd6, 2'b01, 2'd3, 0, 0);
    stepChecked("idle_clip15", 0, 0, 4'd15, '0, 4'd14, 4'd15, 2'b01, 2'd3, 0, 0);
    stepChecked("idle_back", 0, 0, 4'd5, '0, 4'd14, 4'd6, 2'b01, 2'd3, 0, 0);
    stepChecked("launch", 0, 1, 4'd5, '0, 4'd14, 4'd6, 2'b01, 2'd3, 0, 0);
    stepChecked("first_move", 1, 0, 4'd5, '0, 4'd13, 4'd7, 2'b01, 2'd3, 0, 0);
    stepChecked("fly_hold", 0, 0, 4'd5, '0, 4'd13, 4'd7, 2'b01, 2'd3, 0, 0);

    // Right wall at row 3 then top wall.
    doReset("reset_before_wall");
    stepChecked("wall_launch", 0, 1, 4'd3, '0, 4'd14, 4'd4, 2'b01, 2'd3, 0, 0);
    for (int j = 1; j <= 11; j++)
      stepChecked($sformatf("wall_up%0d", j), 1, 0, 4'd3, '0, 4'(14 - j), 4'(4 + j), 2'b01,
                  2'd3, 0, 0);
    stepChecked("right_wall", 1, 0, 4'd3, '0, 4'd2, 4'd14, 2'b00, 2'd3, 0, 0);
    stepChecked("upleft1", 1, 0, 4'd3, '0, 4'd1, 4'd13, 2'b00, 2'd3, 0, 0);
    stepChecked("upleft2", 1, 0, 4'd3, '0, 4'd0, 4'd12, 2'b00, 2'd3, 0, 0);
    stepChecked("top_wall", 1, 0, 4'd3, '0, 4'd1, 4'd11, 2'b10, 2'd3, 0, 0);
    stepChecked("downleft", 1, 0, 4'd3, '0, 4'd2, 4'd10, 2'b10, 2'd3, 0, 0);

    // Brick bounce, clipped paddle hit, then left and top walls.
    doReset("reset_before_brick");
    stepChecked("brick_launch", 0, 1, 4'd0, '0, 4'd14, 4'd1, 2'b01, 2'd3, 0, 0);
    for (int j = 1; j <= 6; j++)
      stepChecked($sformatf("brick_outofrange%0d", j), 1, 0, 4'd0, ALL_BRICKS, 4'(14 - j),
                  4'(1 + j), 2'b01, 2'd3, 0, 0);
    stepChecked("brick_fly_hold", 0, 0, 4'd0, ALL_BRICKS, 4'd8, 4'd7, 2'b01, 2'd3, 0, 0);
    stepChecked("brick_hit52", 1, 0, 4'd0, BRICK_52, 4'd8, 4'd8, 2'b11, 2'd3, 0, 0);
    for (int j = 8; j <= 13; j++)
      stepChecked($sformatf("brick_down%0d", j), 1, 0, 4'd0, '0, 4'(j + 1), 4'(j + 1), 2'b11,
                  2'd3, 0, 0);
    stepChecked("paddle_hit_clipped", 1, 0, 4'd14, '0, 4'd14, 4'd15, 2'b01, 2'd3, 0, 0);
    stepChecked("right_wall2", 1, 0, 4'd14, '0, 4'd13, 4'd14, 2'b00, 2'd3, 0, 0);
    for (int m = 1; m <= 13; m++)
      stepChecked($sformatf("climb%0d", m), 1, 0, 4'd14, '0, 4'(13 - m), 4'(14 - m), 2'b00,
                  2'd3, 0, 0);
    stepChecked("top_at_col0", 1, 0, 4'd14, '0, 4'd1, 4'd0, 2'b10, 2'd3, 0, 0);
    stepChecked("left_wall", 1, 0, 4'd14, '0, 4'd2, 4'd1, 2'b11, 2'd3, 0, 0);

    // One life lost, then reset in mid flight restores everything.
    doReset("reset_before_loss");
    runLoss();
    stepChecked("midfly_serve", 0, 1, 4'd0, '0, 4'd14, 4'd1, 2'b01, 2'd2, 0, 0);
    for (int j = 1; j <= 3; j++)
      stepChecked($sformatf("midfly_up%0d", j), 1, 0, 4'd0, '0, 4'(14 - j), 4'(1 + j), 2'b01,
                  2'd2, 0, 0);
    doReset("reset_midfly");

    // Lose all lives, game over ignores inputs, reset recovers.
    runLoss();
    runLoss();
    runLoss();
    stepChecked("over_launch_ignored", 1, 1, 4'd0, '0, 4'd15, 4'd15, 2'b11, 2'd0, 0, 1);
    stepChecked("over_still", 1, 1, 4'd6, ALL_BRICKS, 4'd15, 4'd15, 2'b11, 2'd0, 0, 1);
    doReset("reset_after_over");
    stepChecked("idle_after_over", 0, 0, 4'd5, '0, 4'd14, 4'd6, 2'b01, 2'd3, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
